// File: rtl/qcl_breath_seq.sv
// Command-driven breathing/blink sequencer: accepts (half-period, transition count)
// and flips `o` every half-period of en_i events, retiring with a 1-cycle done_o.
module qcl_breath_seq #(
  parameter int width_p     = 24,
  parameter int cnt_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     half_period_i,
  input  logic [cnt_width_p-1:0] toggles_i,
  input  logic                   abort_i,
  output logic                   o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [cnt_width_p-1:0] toggles_left_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [width_p-1:0]     hp_one_lp  = width_p'(1);
  localparam logic [cnt_width_p-1:0] tog_one_lp = cnt_width_p'(1);

  state_e                 state_q, state_d;
  logic [width_p-1:0]     cnt_q, cnt_d;
  logic [width_p-1:0]     hp_q, hp_d;
  logic [cnt_width_p-1:0] tl_q, tl_d;
  logic                   cont_q, cont_d;
  logic                   o_q, o_d;

  // Handshake: a command transfers on any clock edge where v_i & ready_o;
  // ready_o depends on state only, and v_i outside IDLE is simply ignored.
  assign ready_o        = (state_q == IDLE);
  assign busy_o         = (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign o              = o_q;
  assign toggles_left_o = tl_q;
  assign state_o        = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    tl_d    = tl_q;
    cont_d  = cont_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          state_d = RUN;
          hp_d    = (half_period_i == '0) ? hp_one_lp : half_period_i;
          tl_d    = toggles_i;
          cont_d  = (toggles_i == '0);
          cnt_d   = '0;
          o_d     = 1'b0;
        end
      end
      RUN: begin
        // Abort takes priority over a terminal transition in the same cycle.
        if (abort_i) begin
          state_d = DONE;
          o_d     = 1'b0;
          cnt_d   = '0;
          tl_d    = '0;
        end else if (en_i) begin
          if (cnt_q == hp_q - hp_one_lp) begin
            cnt_d = '0;
            o_d   = ~o_q;
            if (!cont_q && tl_q != '0) begin
              tl_d = tl_q - tog_one_lp;
              if (tl_q == tog_one_lp) state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + hp_one_lp;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      tl_q    <= '0;
      cont_q  <= 1'b0;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      tl_q    <= tl_d;
      cont_q  <= cont_d;
      o_q     <= o_d;
    end
  end

endmodule
